gpio_irq: RTL and testbench

Parametrised GPIO bank with a per-pin interrupt unit, generalising the existing fixed-width GPIO/pending logic.
- Adds input synchronisers, per-pin level/edge selection, polarity and any-edge modes, sticky write-1-to-clear pending bits, and a registered interrupt output.
- Sits on the byte-wide peripheral register bus; drives the chip's output and bidirectional pads.
- Feeds the interrupt controller.

---
 rtl/gpio_irq_if.sv | 9 +
 rtl/gpio_irq.sv | 100 ++++++++++
 tb/tb_gpio_irq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: byte-wide peripheral register bus between the CPU side and the GPIO bank
interface gpio_irq_if;
   logic [4:0] reg_addr;
   logic [7:0] reg_data_in;
   logic [7:0] reg_data_out;
   logic       reg_write;
   modport master (output reg_addr, reg_data_in, reg_write, input reg_data_out);
   modport slave (input reg_addr, reg_data_in, reg_write, output reg_data_out);
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO bank with synchronised inputs and a per-pin level/edge interrupt unit
module gpio_irq_bank #(
   parameter int W = 8,
   parameter int SYNC_STAGES = 2,
   parameter int OFS = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] pad,
   input  logic         write,
   input  logic [4:0]   addr,
   input  logic [7:0]   wdata,
   output logic [7:0]   rdata,
   output logic         hit
);
   localparam logic [4:0] A_PEND = 5'(OFS);
   localparam logic [4:0] A_STAT = 5'(OFS + 2);
   localparam logic [4:0] A_EN   = 5'(OFS + 4);
   localparam logic [4:0] A_MODE = 5'(OFS + 6);
   localparam logic [4:0] A_POL  = 5'(OFS + 8);
   localparam logic [4:0] A_ANY  = 5'(OFS + 10);
   logic [SYNC_STAGES-1:0][W-1:0] sync;
   logic [W-1:0] d, s, s_d, en, mode, pol, any_edge, epend, ev, pend, clr;
   assign d = wdata[W-1:0];
   assign s = sync[SYNC_STAGES-1];
   assign ev = any_edge & (s ^ s_d) | ~any_edge & ~pol & s & ~s_d | ~any_edge & pol & ~s & s_d;
   assign pend = mode & epend | ~mode & (s ^ pol);
   assign clr = write && addr == A_PEND ? d : '0;
   assign hit = |(pend & en);
   assign rdata = addr == A_PEND ? 8'(pend) :
                  addr == A_STAT ? 8'(s) :
                  addr == A_EN   ? 8'(en) :
                  addr == A_MODE ? 8'(mode) :
                  addr == A_POL  ? 8'(pol) :
                  addr == A_ANY  ? 8'(any_edge) : '0;
   // stored edge bits are held clear outside edge mode, so mode switches never resurrect old events
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         s_d <= '0;
         en <= '0;
         mode <= '0;
         pol <= '0;
         any_edge <= '0;
         epend <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pad};
         s_d <= s;
         en <= write && addr == A_EN ? d : en;
         mode <= write && addr == A_MODE ? d : mode;
         pol <= write && addr == A_POL ? d : pol;
         any_edge <= write && addr == A_ANY ? d : any_edge;
         epend <= (epend & ~clr | ev) & mode;
      end
   end
endmodule

module gpio_irq #(
   parameter int N_IN = 8,
   parameter int N_IO = 4,
   parameter int N_OUT = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IN-1:0]  gpio_in,
   input  logic [N_IO-1:0]  gpio_io_in,
   output logic [N_IO-1:0]  gpio_io_out,
   output logic [N_IO-1:0]  gpio_io_oe,
   output logic [N_OUT-1:0] gpio_out,
   output logic             interrupt,
   gpio_irq_if.slave        bus
);
   logic [7:0] rd_in, rd_io;
   logic hit_in, hit_io;
   gpio_irq_bank #(.W(N_IN), .SYNC_STAGES(SYNC_STAGES), .OFS(0)) u_in (
      .clk(clk), .reset(reset), .pad(gpio_in), .write(bus.reg_write), .addr(bus.reg_addr),
      .wdata(bus.reg_data_in), .rdata(rd_in), .hit(hit_in));
   gpio_irq_bank #(.W(N_IO), .SYNC_STAGES(SYNC_STAGES), .OFS(1)) u_io (
      .clk(clk), .reset(reset), .pad(gpio_io_in), .write(bus.reg_write), .addr(bus.reg_addr),
      .wdata(bus.reg_data_in), .rdata(rd_io), .hit(hit_io));
   assign bus.reg_data_out = rd_in | rd_io |
                             (bus.reg_addr == 5'd12 ? 8'(gpio_out) :
                              bus.reg_addr == 5'd13 ? 8'(gpio_io_out) :
                              bus.reg_addr == 5'd14 ? 8'(gpio_io_oe) :
                              bus.reg_addr == 5'd16 ? {6'd0, hit_io, hit_in} : 8'd0);
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_out <= '0;
         gpio_io_out <= '0;
         gpio_io_oe <= '0;
         interrupt <= 1'b0;
      end else begin
         if (bus.reg_write && bus.reg_addr == 5'd12) gpio_out <= bus.reg_data_in[N_OUT-1:0];
         if (bus.reg_write && bus.reg_addr == 5'd13) gpio_io_out <= bus.reg_data_in[N_IO-1:0];
         if (bus.reg_write && bus.reg_addr == 5'd14) gpio_io_oe <= bus.reg_data_in[N_IO-1:0];
         interrupt <= hit_in | hit_io;
      end
   end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq with default parameters
module tb_gpio_irq;
   logic clk = 0, reset = 1;
   logic [7:0] gpio_in;
   logic [3:0] gpio_io_in, gpio_io_out, gpio_io_oe;
   logic [4:0] gpio_out;
   logic interrupt;
   int checks = 0, failures = 0;
   gpio_irq_if bus();
   gpio_irq dut (.clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_io_in(gpio_io_in),
      .gpio_io_out(gpio_io_out), .gpio_io_oe(gpio_io_oe), .gpio_out(gpio_out),
      .interrupt(interrupt), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chkreg(input string tag, input logic [4:0] a, input logic [7:0] exp);
      bus.reg_addr = a;
      #1;
      chk(tag, bus.reg_data_out, exp);
   endtask
   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      bus.reg_addr = a;
      bus.reg_data_in = d;
      bus.reg_write = 1;
      tick(1);
      bus.reg_write = 0;
   endtask
   initial begin
      gpio_in = 8'hFF;
      gpio_io_in = 4'hF;
      bus.reg_addr = 0;
      bus.reg_data_in = 0;
      bus.reg_write = 0;
      tick(3);
      chk("rst_gpio_out", gpio_out, 0);
      chk("rst_io_out", gpio_io_out, 0);
      chk("rst_io_oe", gpio_io_oe, 0);
      chkreg("rst_reg0", 0, 0);
      chkreg("rst_reg1", 1, 0);
      chkreg("rst_reg4", 4, 0);
      chkreg("rst_reg16", 16, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("rst_irq", interrupt, 0);
      end
      gpio_in = 0;
      gpio_io_in = 0;
      tick(1);
      reset = 0;
      tick(4);
      chk("idle_irq", interrupt, 0);
      // rising edge on pin 0
      wr(6, 8'h01);
      wr(4, 8'h01);
      gpio_in = 8'h01;
      tick(2);
      chkreg("rise_early", 0, 8'h00);
      tick(1);
      chkreg("rise_pend", 0, 8'h01);
      chk("rise_irq_early", interrupt, 0);
      tick(1);
      chk("rise_irq", interrupt, 1);
      gpio_in = 0;
      tick(4);
      chk("rise_irq_sticky", interrupt, 1);
      chkreg("rise_pend_sticky", 0, 8'h01);
      wr(0, 8'h01);
      chk("w1c_irq_lag", interrupt, 1);
      chkreg("w1c_pend", 0, 8'h00);
      tick(1);
      chk("w1c_irq", interrupt, 0);
      // W1C colliding with a falling any-edge event on pin 3
      wr(10, 8'h08);
      wr(6, 8'h09);
      gpio_in = 8'h08;
      tick(3);
      chkreg("any_rise", 0, 8'h08);
      gpio_in = 0;
      tick(2);
      wr(0, 8'h08);
      chkreg("collide", 0, 8'h08);
      wr(0, 8'h08);
      chkreg("collide_clr", 0, 8'h00);
      // level-low on io pin 1
      wr(9, 8'h02);
      wr(5, 8'h02);
      chk("lvl_irq_lag", interrupt, 0);
      tick(1);
      chk("lvl_irq", interrupt, 1);
      chkreg("lvl_pend", 1, 8'h02);
      chkreg("lvl_sum", 16, 8'h02);
      wr(1, 8'h02);
      chkreg("lvl_w1c", 1, 8'h02);
      gpio_io_in = 4'h2;
      tick(2);
      chkreg("lvl_clear", 1, 8'h00);
      chk("lvl_irq_hold", interrupt, 1);
      tick(1);
      chk("lvl_irq_clear", interrupt, 0);
      wr(5, 0);
      wr(9, 0);
      // outputs and width masking
      wr(12, 8'hFF);
      chk("gpio_out", gpio_out, 5'h1F);
      wr(13, 8'hFF);
      chk("io_out", gpio_io_out, 4'hF);
      wr(14, 8'hFF);
      chk("io_oe", gpio_io_oe, 4'hF);
      chkreg("rd12", 12, 8'h1F);
      chkreg("rd13", 13, 8'h0F);
      chkreg("rd14", 14, 8'h0F);
      chkreg("stat_io_oe", 3, 8'h02);
      chkreg("unmapped", 15, 8'h00);
      // enable gating on pin 5
      wr(4, 0);
      wr(6, 8'h20);
      gpio_in = 8'h20;
      tick(4);
      chkreg("gate_pend", 0, 8'h20);
      chk("gate_irq_off", interrupt, 0);
      chkreg("gate_stat", 2, 8'h20);
      wr(4, 8'h20);
      chk("gate_irq_lag", interrupt, 0);
      tick(1);
      chk("gate_irq_on", interrupt, 1);
      // edge->level->edge discards the stored bit
      wr(8, 8'h20);
      wr(6, 0);
      tick(1);
      wr(6, 8'h20);
      chkreg("mode_discard", 0, 8'h00);
      tick(1);
      chk("mode_irq", interrupt, 0);
      // reset mid-operation
      reset = 1;
      tick(1);
      reset = 0;
      chk("mid_rst_out", gpio_out, 0);
      chk("mid_rst_oe", gpio_io_oe, 0);
      chkreg("mid_rst_en", 4, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
